prbs_ber_controller: RTL and testbench

- Sequences a self-synchronising PRBS checker for BER measurement on one 32-bit lane.
- Seeds its prediction from received words and declares lock after a run of matches.
- While locked, counts words, errored words and errored bits; detects loss of lock and ends the test on a programmed duration or a stop request.
- Sits downstream of a PRBS generator/link and feeds status and counters to a register block.

---
 rtl/prbs_ctrl_pkg.sv | 33 +++
 rtl/prbs_ber_controller_popcount32.sv | 17 +
 rtl/prbs_ber_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_prbs_ber_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_ctrl_pkg.sv
// Shared types, tap masks and the LFSR step function for the PRBS BER controller.
package prbs_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [31:0] PRBS7_MASK  = 32'h0000_0060;
    localparam logic [31:0] PRBS15_MASK = 32'h0000_6000;
    localparam int          MAX_ITER    = 64;

    // Shift left with the tap-parity feedback bit entering at the LSB.
    function automatic logic [31:0] lfsr_advance(
        input logic [31:0] state,
        input int          iterations,
        input logic [31:0] poly
    );
        logic [31:0] s;
        s = state;
        for (int i = 0; i < MAX_ITER; i++) begin
            if (i < iterations) begin
                s = {s[30:0], ^(s & poly)};
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/prbs_ber_controller_popcount32.sv
// Combinational population count of a 32-bit word.
module popcount32
    import prbs_ctrl_pkg::*;
(
    input  logic [31:0] data,
    output logic [5:0]  count
);

    // Sum of the set bits.
    always_comb begin
        count = 6'd0;
        for (int i = 0; i < 32; i++) begin
            count = count + {5'd0, data[i]};
        end
    end

endmodule

// File: rtl/prbs_ber_controller.sv
// Self-synchronising PRBS checker sequencer with BER counters.
// Optional build macro PRBS_BER_ERR_INJECT_EN adds an err_inject input flipping rx bit 0.
module prbs_ber_controller
    import prbs_ctrl_pkg::*;
#(
    parameter logic [31:0] POLY         = 32'h0000_6000,
    parameter int          ITERATIONS   = 32,
    parameter int          LOCK_COUNT   = 8,
    parameter int          UNLOCK_COUNT = 4,
    parameter int          CNT_W        = 48
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             start,
    input  logic             stop,
`ifdef PRBS_BER_ERR_INJECT_EN
    input  logic             err_inject,
`endif
    input  logic [CNT_W-1:0] duration,
    output logic             locked,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_word_count,
    output logic [CNT_W-1:0] err_bit_count,
    output logic [15:0]      lock_loss_count
);

    localparam logic [7:0]       LOCK_LAST   = 8'(LOCK_COUNT - 1);
    localparam logic [7:0]       UNLOCK_LAST = 8'(UNLOCK_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [31:0]      prev_q, prev_d;
    logic             seed_valid_q, seed_valid_d;
    logic [7:0]       match_cnt_q, match_cnt_d;
    logic [7:0]       bad_cnt_q, bad_cnt_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [CNT_W-1:0] err_word_q, err_word_d;
    logic [CNT_W-1:0] err_bit_q, err_bit_d;
    logic [15:0]      lock_loss_q, lock_loss_d;
    logic             locked_q, locked_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [31:0]      rx_s;
    logic [31:0]      predicted_s;
    logic [31:0]      err_vec_s;
    logic [5:0]       err_bits_s;
    logic [CNT_W-1:0] err_bits_ext_s;
    logic [CNT_W:0]   word_next_s;
    logic             dur_hit_s;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CNT_W]) begin
            return '1;
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

`ifdef PRBS_BER_ERR_INJECT_EN
    assign rx_s = s_axis_tdata ^ {31'd0, err_inject};
`else
    assign rx_s = s_axis_tdata;
`endif

    assign predicted_s    = lfsr_advance(prev_q, ITERATIONS, POLY);
    assign err_vec_s      = rx_s ^ predicted_s;
    assign err_bits_ext_s = {{(CNT_W-6){1'b0}}, err_bits_s};
    assign word_next_s    = {1'b0, word_count_q} + {1'b0, CNT_ONE};
    assign dur_hit_s      = (duration != {CNT_W{1'b0}}) && (word_next_s == {1'b0, duration});

    popcount32 u_popcount (
        .data  (err_vec_s),
        .count (err_bits_s)
    );

    // Next-state, counter and status computation.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        seed_valid_d = seed_valid_q;
        match_cnt_d  = match_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        word_count_d = word_count_q;
        err_word_d   = err_word_q;
        err_bit_d    = err_bit_q;
        lock_loss_d  = lock_loss_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = SYNC;
                    seed_valid_d = 1'b0;
                    match_cnt_d  = 8'd0;
                    bad_cnt_d    = 8'd0;
                    word_count_d = {CNT_W{1'b0}};
                    err_word_d   = {CNT_W{1'b0}};
                    err_bit_d    = {CNT_W{1'b0}};
                    lock_loss_d  = 16'd0;
                end else begin
                    state_d = state_q;
                end
            end
            SYNC: begin
                if (s_axis_tvalid) begin
                    prev_d = rx_s;
                    if (!seed_valid_q) begin
                        seed_valid_d = 1'b1;
                    end else if (err_vec_s == 32'd0) begin
                        if (match_cnt_q == LOCK_LAST) begin
                            state_d     = RUN;
                            match_cnt_d = 8'd0;
                            bad_cnt_d   = 8'd0;
                        end else begin
                            match_cnt_d = match_cnt_q + 8'd1;
                        end
                    end else begin
                        match_cnt_d = 8'd0;
                    end
                end else begin
                    prev_d = prev_q;
                end
                if (stop) begin
                    state_d = DONE;
                end else begin
                    state_d = state_d;
                end
            end
            RUN: begin
                if (s_axis_tvalid) begin
                    prev_d       = rx_s;
                    word_count_d = sat_add(word_count_q, CNT_ONE);
                    if (err_vec_s != 32'd0) begin
                        err_word_d = sat_add(err_word_q, CNT_ONE);
                        err_bit_d  = sat_add(err_bit_q, err_bits_ext_s);
                        if (bad_cnt_q == UNLOCK_LAST) begin
                            // Resync re-uses prev as the seed, so seed_valid stays set.
                            state_d     = SYNC;
                            bad_cnt_d   = 8'd0;
                            match_cnt_d = 8'd0;
                            lock_loss_d = (lock_loss_q == 16'hFFFF) ? lock_loss_q : lock_loss_q + 16'd1;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 8'd1;
                        end
                    end else begin
                        bad_cnt_d = 8'd0;
                    end
                    if (dur_hit_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = state_d;
                    end
                end else begin
                    prev_d = prev_q;
                end
                if (stop) begin
                    state_d = DONE;
                end else begin
                    state_d = state_d;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        locked_d = (state_d == RUN);
        done_d   = (state_d == DONE);
        busy_d   = (state_d == SYNC) || (state_d == RUN);
    end

    // State, datapath and registered status flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            prev_q       <= 32'd0;
            seed_valid_q <= 1'b0;
            match_cnt_q  <= 8'd0;
            bad_cnt_q    <= 8'd0;
            word_count_q <= {CNT_W{1'b0}};
            err_word_q   <= {CNT_W{1'b0}};
            err_bit_q    <= {CNT_W{1'b0}};
            lock_loss_q  <= 16'd0;
            locked_q     <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            seed_valid_q <= seed_valid_d;
            match_cnt_q  <= match_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            word_count_q <= word_count_d;
            err_word_q   <= err_word_d;
            err_bit_q    <= err_bit_d;
            lock_loss_q  <= lock_loss_d;
            locked_q     <= locked_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign s_axis_tready   = 1'b1;
    assign locked          = locked_q;
    assign done            = done_q;
    assign busy            = busy_q;
    assign word_count      = word_count_q;
    assign err_word_count  = err_word_q;
    assign err_bit_count   = err_bit_q;
    assign lock_loss_count = lock_loss_q;

endmodule

// File: tb/tb_prbs_ber_controller.sv
// Scoreboard bench for prbs_ber_controller on a PRBS7 stream.
module tb_prbs_ber_controller;

    localparam int CNT_W  = 48;
    localparam int LOCK   = 8;
    localparam int UNLOCK = 4;
`ifdef PRBS_BER_ERR_INJECT_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             aresetn;
    logic [31:0]      s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] duration;
    logic             locked, done, busy;
    logic [CNT_W-1:0] word_count, err_word_count, err_bit_count;
    logic [15:0]      lock_loss_count;
`ifdef PRBS_BER_ERR_INJECT_EN
    logic             err_inject;
`endif

    prbs_ber_controller #(.POLY(32'h0000_0060)) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .start           (start),
        .stop            (stop),
`ifdef PRBS_BER_ERR_INJECT_EN
        .err_inject      (err_inject),
`endif
        .duration        (duration),
        .locked          (locked),
        .done            (done),
        .busy            (busy),
        .word_count      (word_count),
        .err_word_count  (err_word_count),
        .err_bit_count   (err_bit_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {M_IDLE, M_SYNC, M_RUN, M_DONE} mst_e;
    typedef struct {
        logic             locked, done, busy;
        logic [CNT_W-1:0] wc, ewc, ebc;
        logic [15:0]      llc;
    } exp_t;

    exp_t             exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    mst_e             m_st;
    logic [31:0]      m_prev;
    logic             m_seed;
    int               m_match, m_bad;
    logic [CNT_W-1:0] m_wc, m_ewc, m_ebc;
    logic [15:0]      m_llc;
    logic [31:0]      gen;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // PRBS7 next word via the bit recurrence b[n] = b[n-6] ^ b[n-7].
    function automatic logic [31:0] next_word(input logic [31:0] w);
        logic        seq [0:63];
        logic [31:0] r;
        for (int i = 0; i < 32; i++) seq[i] = w[31-i];
        for (int i = 32; i < 64; i++) seq[i] = seq[i-6] ^ seq[i-7];
        for (int k = 0; k < 32; k++) r[k] = seq[63-k];
        return r;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_prev = 32'd0; m_seed = 1'b0; m_match = 0; m_bad = 0;
        m_wc = '0; m_ewc = '0; m_ebc = '0; m_llc = 16'd0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] rx, input logic st, input logic sp);
        logic [31:0] e;
        mst_e        nx;
        nx = m_st;
        e  = rx ^ next_word(m_prev);
        case (m_st)
            M_IDLE, M_DONE: if (st) begin
                nx = M_SYNC; m_seed = 1'b0; m_match = 0; m_bad = 0;
                m_wc = '0; m_ewc = '0; m_ebc = '0; m_llc = 16'd0;
            end
            M_SYNC: begin
                if (v) begin
                    if (!m_seed) m_seed = 1'b1;
                    else if (e == 32'd0) begin
                        m_match++;
                        if (m_match == LOCK) begin nx = M_RUN; m_match = 0; m_bad = 0; end
                    end else m_match = 0;
                    m_prev = rx;
                end
                if (sp) nx = M_DONE;
            end
            M_RUN: begin
                if (v) begin
                    m_wc++;
                    if (e != 32'd0) begin
                        m_ewc++;
                        m_ebc += CNT_W'($countones(e));
                        m_bad++;
                        if (m_bad == UNLOCK) begin nx = M_SYNC; m_llc++; m_match = 0; m_bad = 0; end
                    end else m_bad = 0;
                    if (duration != '0 && m_wc == duration) nx = M_DONE;
                    m_prev = rx;
                end
                if (sp) nx = M_DONE;
            end
            default: nx = M_IDLE;
        endcase
        m_st = nx;
    endtask

    // Drive one cycle, push the model's expectation, then pop and compare after the edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic st, input logic sp, input logic inj);
        exp_t e;
        s_axis_tvalid = v; s_axis_tdata = d; start = st; stop = sp;
`ifdef PRBS_BER_ERR_INJECT_EN
        err_inject = inj;
`endif
        model_step(v, d ^ {31'd0, inj & INJ_ON}, st, sp);
        exp_q.push_back('{locked: (m_st == M_RUN), done: (m_st == M_DONE),
                          busy: (m_st == M_SYNC || m_st == M_RUN),
                          wc: m_wc, ewc: m_ewc, ebc: m_ebc, llc: m_llc});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        check_val("sb_locked", 64'(locked), 64'(e.locked));
        check_val("sb_done", 64'(done), 64'(e.done));
        check_val("sb_busy", 64'(busy), 64'(e.busy));
        check_val("sb_word_count", 64'(word_count), 64'(e.wc));
        check_val("sb_err_word", 64'(err_word_count), 64'(e.ewc));
        check_val("sb_err_bit", 64'(err_bit_count), 64'(e.ebc));
        check_val("sb_lock_loss", 64'(lock_loss_count), 64'(e.llc));
        s_axis_tvalid = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef PRBS_BER_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
    endtask

    task automatic send_clean();
        gen = next_word(gen);
        cycle(1'b1, gen, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        aresetn = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_val({tag, "_locked"}, 64'(locked), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_wc"}, 64'(word_count), 64'd0);
        check_val({tag, "_ewc"}, 64'(err_word_count), 64'd0);
        check_val({tag, "_ebc"}, 64'(err_bit_count), 64'd0);
        check_val({tag, "_llc"}, 64'(lock_loss_count), 64'd0);
        aresetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0]      corrupt, good;
        logic [CNT_W-1:0] wc_before;
        int               prop;
        aresetn = 1'b0; s_axis_tdata = 32'd0; s_axis_tvalid = 1'b0;
        start = 1'b0; stop = 1'b0; duration = '0;
`ifdef PRBS_BER_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        gen = 32'hACE1_0001;
        @(posedge clk);
        do_reset("reset");
        check_val("tready", 64'(s_axis_tready), 64'd1);

        // Start together with stop from IDLE: start wins; lock on the 9th word.
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check_val("idle_start_busy", 64'(busy), 64'd1);
        repeat (8) send_clean();
        check_val("lock_after8", 64'(locked), 64'd0);
        send_clean();
        check_val("lock_after9", 64'(locked), 64'd1);
        check_val("lock_wc", 64'(word_count), 64'd0);

        // Duration-limited clean run.
        duration = 48'd1000;
        repeat (1000) send_clean();
        check_val("dur_done", 64'(done), 64'd1);
        check_val("dur_wc", 64'(word_count), 64'd1000);
        check_val("dur_ewc", 64'(err_word_count), 64'd0);
        check_val("dur_ebc", 64'(err_bit_count), 64'd0);
        send_clean();
        check_val("dur_hold", 64'(word_count), 64'd1000);

        // Restart from DONE with concurrent stop, then a 3-bit corrupted word.
        duration = '0;
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check_val("done_start_busy", 64'(busy), 64'd1);
        check_val("done_start_clear", 64'(word_count), 64'd0);
        repeat (9) send_clean();
        gen     = next_word(gen);
        good    = gen;
        corrupt = good ^ 32'h8000_0021;
        cycle(1'b1, corrupt, 1'b0, 1'b0, 1'b0);
        prop = $countones(next_word(corrupt) ^ next_word(good));
        repeat (3) send_clean();
        check_val("flip_ewc", 64'(err_word_count), 64'd2);
        check_val("flip_ebc", 64'(err_bit_count), 64'(3 + prop));
        check_val("flip_locked", 64'(locked), 64'd1);

        // Four random words force resync; clean stream relocks (first clean word mismatches the random seed).
        repeat (4) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        check_val("unlock_locked", 64'(locked), 64'd0);
        check_val("unlock_llc", 64'(lock_loss_count), 64'd1);
        check_val("unlock_busy", 64'(busy), 64'd1);
        repeat (9) send_clean();
        check_val("relock", 64'(locked), 64'd1);

        // Gappy valid, ignored start in RUN, stop with a concurrent word.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) send_clean();
            else cycle(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
        end
        gen = next_word(gen);
        cycle(1'b1, gen, 1'b1, 1'b0, 1'b0);
        wc_before = word_count;
        gen = next_word(gen);
        cycle(1'b1, gen, 1'b0, 1'b1, 1'b0);
        check_val("stop_wc", 64'(word_count), 64'(wc_before + 48'd1));
        check_val("stop_done", 64'(done), 64'd1);
        repeat (5) send_clean();
        check_val("stop_frozen", 64'(word_count), 64'(wc_before + 48'd1));

        // Reset in the middle of RUN.
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        repeat (12) send_clean();
        do_reset("midrun_reset");

`ifdef PRBS_BER_ERR_INJECT_EN
        // Injected error: exactly one bit on that word.
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        repeat (9) send_clean();
        gen = next_word(gen);
        cycle(1'b1, gen, 1'b0, 1'b0, 1'b1);
        check_val("inject_ebc", 64'(err_bit_count), 64'd1);
        repeat (2) send_clean();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
